// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register with valid bit, hold, bubble, flush,
// selectable capture edge and saturating stall/bubble event counters.
module pipe_stage_reg #(
  parameter int                CTRL_W   = 16,
  parameter int                DATA_W   = 224,
  parameter logic [CTRL_W-1:0] CTRL_NOP = '0,
  parameter bit                NEG_EDGE = 1'b1,
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall_in,
  input  logic              bubble_in,
  input  logic              flush_in,
  input  logic              cnt_clr,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic              held_out,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_LOADED = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic              w_captureClk;
  logic [1:0]        r_state;
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;
  logic [CNT_W-1:0]  r_stallCnt;
  logic [CNT_W-1:0]  r_bubbleCnt;

  logic [1:0]        w_stateNext;
  logic              w_validNext;
  logic [CTRL_W-1:0] w_ctrlNext;
  logic [DATA_W-1:0] w_dataNext;
  logic [CNT_W-1:0]  w_stallCntNext;
  logic [CNT_W-1:0]  w_bubbleCntNext;

  // The parameter folds this to either a plain clock or an inverted one.
  assign w_captureClk = NEG_EDGE ? ~clock : clock;

  always_comb begin
    w_stateNext     = r_state;
    w_validNext     = r_valid;
    w_ctrlNext      = r_ctrl;
    w_dataNext      = r_data;
    w_stallCntNext  = r_stallCnt;
    w_bubbleCntNext = r_bubbleCnt;

    if (flush_in) begin
      w_validNext = 1'b0;
      w_ctrlNext  = CTRL_NOP;
      w_stateNext = ST_EMPTY;
    end else if (stall_in) begin
      w_stateNext = ST_HOLD;
      if (r_stallCnt != CNT_MAX) begin
        w_stallCntNext = r_stallCnt + CNT_ONE;
      end
    end else if (bubble_in) begin
      w_validNext = 1'b0;
      w_ctrlNext  = CTRL_NOP;
      w_dataNext  = data_in;
      w_stateNext = ST_EMPTY;
      if (r_bubbleCnt != CNT_MAX) begin
        w_bubbleCntNext = r_bubbleCnt + CNT_ONE;
      end
    end else begin
      w_validNext = valid_in;
      w_ctrlNext  = valid_in ? ctrl_in : CTRL_NOP;
      w_dataNext  = data_in;
      w_stateNext = valid_in ? ST_LOADED : ST_EMPTY;
    end

    // A clear overrides any increment decided above on the same edge.
    if (cnt_clr) begin
      w_stallCntNext  = '0;
      w_bubbleCntNext = '0;
    end
  end

  always_ff @(posedge w_captureClk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_EMPTY;
      r_valid     <= 1'b0;
      r_ctrl      <= CTRL_NOP;
      r_data      <= '0;
      r_stallCnt  <= '0;
      r_bubbleCnt <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_valid     <= w_validNext;
      r_ctrl      <= w_ctrlNext;
      r_data      <= w_dataNext;
      r_stallCnt  <= w_stallCntNext;
      r_bubbleCnt <= w_bubbleCntNext;
    end
  end

  assign valid_out  = r_valid;
  assign ctrl_out   = r_ctrl;
  assign data_out   = r_data;
  assign held_out   = (r_state == ST_HOLD);
  assign stall_cnt  = r_stallCnt;
  assign bubble_cnt = r_bubbleCnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: falling-edge, small-counter and rising-edge instances
// share one stimulus stream and are compared against an abstract per-edge model.
module tb_pipe_stage_reg;

  localparam int CW = 16;
  localparam int DW = 224;

  logic          clock = 1'b0;
  logic          reset;
  logic          stall_in, bubble_in, flush_in, cnt_clr, valid_in;
  logic [CW-1:0] ctrl_in;
  logic [DW-1:0] data_in;

  logic          nValid, sValid, pValid;
  logic [CW-1:0] nCtrl, sCtrl, pCtrl;
  logic [DW-1:0] nData, sData, pData;
  logic          nHeld, sHeld, pHeld;
  logic [15:0]   nStallCnt, nBubbleCnt, pStallCnt, pBubbleCnt;
  logic [1:0]    sStallCnt, sBubbleCnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          valid;
    logic [CW-1:0] ctrl;
    logic [DW-1:0] data;
    logic          held;
    int            stallCnt;
    int            bubbleCnt;
  } model_t;

  model_t mNeg, mSat, mPos;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NEG_EDGE(1'b1), .CNT_W(16)) dutNeg (
    .clock(clock), .reset(reset), .stall_in(stall_in), .bubble_in(bubble_in),
    .flush_in(flush_in), .cnt_clr(cnt_clr), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .valid_out(nValid), .ctrl_out(nCtrl), .data_out(nData),
    .held_out(nHeld), .stall_cnt(nStallCnt), .bubble_cnt(nBubbleCnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NEG_EDGE(1'b1), .CNT_W(2)) dutSat (
    .clock(clock), .reset(reset), .stall_in(stall_in), .bubble_in(bubble_in),
    .flush_in(flush_in), .cnt_clr(cnt_clr), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .valid_out(sValid), .ctrl_out(sCtrl), .data_out(sData),
    .held_out(sHeld), .stall_cnt(sStallCnt), .bubble_cnt(sBubbleCnt));

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .NEG_EDGE(1'b0), .CNT_W(16)) dutPos (
    .clock(clock), .reset(reset), .stall_in(stall_in), .bubble_in(bubble_in),
    .flush_in(flush_in), .cnt_clr(cnt_clr), .valid_in(valid_in), .ctrl_in(ctrl_in),
    .data_in(data_in), .valid_out(pValid), .ctrl_out(pCtrl), .data_out(pData),
    .held_out(pHeld), .stall_cnt(pStallCnt), .bubble_cnt(pBubbleCnt));

  always #5 clock = ~clock;

  function automatic model_t modelReset();
    model_t m;
    m.valid = 1'b0; m.ctrl = '0; m.data = '0; m.held = 1'b0;
    m.stallCnt = 0; m.bubbleCnt = 0;
    return m;
  endfunction

  function automatic model_t modelStep(input model_t m, input int cntMax, input logic vin,
                                       input logic [CW-1:0] cin, input logic [DW-1:0] din,
                                       input logic st, input logic bu, input logic fl,
                                       input logic clr);
    model_t n = m;
    if (fl) begin
      n.valid = 1'b0; n.ctrl = '0; n.held = 1'b0;
    end else if (st) begin
      n.held = 1'b1;
      if (n.stallCnt < cntMax) n.stallCnt = n.stallCnt + 1;
    end else if (bu) begin
      n.valid = 1'b0; n.ctrl = '0; n.data = din; n.held = 1'b0;
      if (n.bubbleCnt < cntMax) n.bubbleCnt = n.bubbleCnt + 1;
    end else begin
      n.valid = vin; n.ctrl = vin ? cin : '0; n.data = din; n.held = 1'b0;
    end
    if (clr) begin
      n.stallCnt = 0; n.bubbleCnt = 0;
    end
    return n;
  endfunction

  function automatic logic [DW-1:0] randData();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < 7; i++) r = {r[DW-33:0], 32'($urandom())};
    return r;
  endfunction

  task automatic checkOutput(input string tag, input model_t m, input logic v,
                             input logic [CW-1:0] c, input logic [DW-1:0] d, input logic h,
                             input logic [31:0] sc, input logic [31:0] bc);
    checks++;
    assert (v === m.valid) else begin
      errors++; $error("FAIL %s.valid obs=%0b exp=%0b", tag, v, m.valid);
    end
    checks++;
    assert (c === m.ctrl) else begin
      errors++; $error("FAIL %s.ctrl obs=%0h exp=%0h", tag, c, m.ctrl);
    end
    checks++;
    assert (d === m.data) else begin
      errors++; $error("FAIL %s.data obs=%0h exp=%0h", tag, d, m.data);
    end
    checks++;
    assert (h === m.held) else begin
      errors++; $error("FAIL %s.held obs=%0b exp=%0b", tag, h, m.held);
    end
    checks++;
    assert (sc === 32'(m.stallCnt)) else begin
      errors++; $error("FAIL %s.stallCnt obs=%0d exp=%0d", tag, sc, m.stallCnt);
    end
    checks++;
    assert (bc === 32'(m.bubbleCnt)) else begin
      errors++; $error("FAIL %s.bubbleCnt obs=%0d exp=%0d", tag, bc, m.bubbleCnt);
    end
  endtask

  task automatic checkValue(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, "/neg"}, mNeg, nValid, nCtrl, nData, nHeld, 32'(nStallCnt), 32'(nBubbleCnt));
    checkOutput({tag, "/sat"}, mSat, sValid, sCtrl, sData, sHeld, 32'(sStallCnt), 32'(sBubbleCnt));
    checkOutput({tag, "/pos"}, mPos, pValid, pCtrl, pData, pHeld, 32'(pStallCnt), 32'(pBubbleCnt));
  endtask

  // Called 2 time units after a falling edge; the rising edge may only move dutPos.
  task automatic applyStimulus(input string tag, input logic vin, input logic [CW-1:0] cin,
                               input logic [DW-1:0] din, input logic st, input logic bu,
                               input logic fl, input logic clr);
    model_t nNeg, nSat, nPos;
    valid_in = vin; ctrl_in = cin; data_in = din;
    stall_in = st; bubble_in = bu; flush_in = fl; cnt_clr = clr;
    nNeg = modelStep(mNeg, 65535, vin, cin, din, st, bu, fl, clr);
    nSat = modelStep(mSat, 3, vin, cin, din, st, bu, fl, clr);
    nPos = modelStep(mPos, 65535, vin, cin, din, st, bu, fl, clr);
    @(posedge clock); #2;
    checkOutput({tag, "/rise/pos"}, nPos, pValid, pCtrl, pData, pHeld, 32'(pStallCnt), 32'(pBubbleCnt));
    checkOutput({tag, "/rise/neg"}, mNeg, nValid, nCtrl, nData, nHeld, 32'(nStallCnt), 32'(nBubbleCnt));
    checkOutput({tag, "/rise/sat"}, mSat, sValid, sCtrl, sData, sHeld, 32'(sStallCnt), 32'(sBubbleCnt));
    @(negedge clock); #2;
    mNeg = nNeg; mSat = nSat; mPos = nPos;
    checkAll({tag, "/fall"});
  endtask

  task automatic pulseReset(input string tag);
    reset = 1'b1;
    #1;
    mNeg = modelReset(); mSat = modelReset(); mPos = modelReset();
    checkAll(tag);
    reset = 1'b0;
  endtask

  initial begin
    $display("[TB] pipe_stage_reg bench start");
    reset = 1'b1;
    stall_in = 1'b0; bubble_in = 1'b0; flush_in = 1'b0; cnt_clr = 1'b0;
    valid_in = 1'b0; ctrl_in = '0; data_in = '0;
    mNeg = modelReset(); mSat = modelReset(); mPos = modelReset();
    #12;
    checkAll("reset");
    reset = 1'b0;

    applyStimulus("load00A5", 1'b1, 16'h00A5, randData(), 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("load00A5.ctrl", DW'(nCtrl), DW'(16'h00A5));
    pulseReset("resetMidStream");

    for (int i = 1; i <= 3; i++) begin
      applyStimulus("normal", 1'b1, 16'($urandom()), DW'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      checkValue("normal.data", nData, DW'(i));
    end

    applyStimulus("loadDEAD", 1'b1, 16'h0101, DW'(32'hDEAD), 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("stall", 1'b1, 16'($urandom()), randData(), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    checkValue("stall.data", nData, DW'(32'hDEAD));
    checkValue("stall.held", DW'(nHeld), DW'(1));
    checkValue("stall.cnt", DW'(nStallCnt), DW'(4));
    checkValue("stall.satCnt", DW'(sStallCnt), DW'(3));

    applyStimulus("stallClr", 1'b1, 16'h0202, randData(), 1'b1, 1'b0, 1'b0, 1'b1);
    checkValue("stallClr.cnt", DW'(nStallCnt), DW'(0));
    checkValue("stallClr.satCnt", DW'(sStallCnt), DW'(0));
    pulseReset("resetMidHold");

    applyStimulus("preBubble", 1'b1, 16'h3333, DW'(5), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("bubble", 1'b1, 16'hFFFF, DW'(7), 1'b0, 1'b1, 1'b0, 1'b0);
    checkValue("bubble.ctrl", DW'(nCtrl), DW'(0));
    checkValue("bubble.valid", DW'(nValid), DW'(0));
    checkValue("bubble.data", nData, DW'(7));
    checkValue("bubble.cnt", DW'(nBubbleCnt), DW'(1));

    applyStimulus("preFlush", 1'b1, 16'h1234, DW'(9), 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("flushAll", 1'b1, 16'hBEEF, DW'(32'h55), 1'b1, 1'b1, 1'b1, 1'b0);
    checkValue("flushAll.valid", DW'(nValid), DW'(0));
    checkValue("flushAll.ctrl", DW'(nCtrl), DW'(0));
    checkValue("flushAll.data", nData, DW'(9));
    checkValue("flushAll.stallCnt", DW'(nStallCnt), DW'(0));
    checkValue("flushAll.bubbleCnt", DW'(nBubbleCnt), DW'(1));

    for (int i = 0; i < 300; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 3) != 0), 16'($urandom()), randData(),
                    1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
